// File: rtl/nts_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// nts_dispatcher_pkg
// Shared NTS definitions for the packet dispatcher: the 64-bit word and
// 8-bit byte-mask widths, their types, and the dispatcher FSM state encoding.
// -----------------------------------------------------------------------------
package nts_dispatcher_pkg;

  localparam int unsigned NTS_WORD_W = 64;
  localparam int unsigned NTS_MASK_W = 8;

  typedef logic [NTS_WORD_W-1:0] nts_word_t;
  typedef logic [NTS_MASK_W-1:0] nts_mask_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WRITE = 2'd1,
    ST_READY = 2'd2,
    ST_DROP  = 2'd3
  } nts_disp_state_e;

endpackage

// File: rtl/nts_dispatcher_if.sv
// -----------------------------------------------------------------------------
// nts_dispatcher_if
// Bundles the MAC receive side, the engine dispatch side and the statistics
// counters of the dispatcher.
//   master : drives the i_* signals (MAC + engine), observes the o_* signals
//   slave  : the dispatcher itself
// -----------------------------------------------------------------------------
interface nts_dispatcher_if;
  import nts_dispatcher_pkg::*;

  // MAC receive side
  nts_mask_t   i_rx_data_valid;
  nts_word_t   i_rx_data;
  logic        i_rx_good_frame;
  logic        i_rx_bad_frame;
  // engine dispatch side
  logic        o_dispatch_packet_available;
  logic        i_dispatch_packet_read_discard;
  nts_mask_t   o_dispatch_data_valid;
  logic        o_dispatch_fifo_empty;
  logic        i_dispatch_fifo_rd_en;
  nts_word_t   o_dispatch_fifo_rd_data;
  // statistics
  logic [31:0] o_counter_frames;
  logic [31:0] o_counter_drops;

  modport master (
    output i_rx_data_valid, i_rx_data, i_rx_good_frame, i_rx_bad_frame,
           i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    input  o_dispatch_packet_available, o_dispatch_data_valid,
           o_dispatch_fifo_empty, o_dispatch_fifo_rd_data,
           o_counter_frames, o_counter_drops
  );

  modport slave (
    input  i_rx_data_valid, i_rx_data, i_rx_good_frame, i_rx_bad_frame,
           i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    output o_dispatch_packet_available, o_dispatch_data_valid,
           o_dispatch_fifo_empty, o_dispatch_fifo_rd_data,
           o_counter_frames, o_counter_drops
  );

endinterface

// File: rtl/nts_dispatcher_ram.sv
// -----------------------------------------------------------------------------
// nts_dispatcher_ram
// Simple dual-port packet buffer, 2**ADDR_WIDTH x 64, one write port and one
// read port with a registered read (data appears the cycle after i_rd_en).
// The array is never reset; only the read register is.
//   i_clk, i_areset       : clock, asynchronous active-high reset
//   i_wr_en/addr/data     : write port
//   i_rd_en/addr, o_rd_data : read port
// -----------------------------------------------------------------------------
module nts_dispatcher_ram
  import nts_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  nts_word_t             i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output nts_word_t             o_rd_data
);

  nts_word_t mem_q [0:(1<<ADDR_WIDTH)-1];
  nts_word_t rd_data_q;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      rd_data_q <= '0;
    end else if (i_rd_en) begin
      rd_data_q <= mem_q[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/nts_dispatcher.sv
// -----------------------------------------------------------------------------
// nts_dispatcher
// Captures one MAC frame at a time into a packet buffer and hands it to the
// NTS engine. Frames arriving while a packet is held, frames overflowing the
// buffer and corrupt frames are dropped whole.
//   i_clk    : clock, rising edge
//   i_areset : asynchronous active-high reset
//   bus      : nts_dispatcher_if.slave (MAC rx, engine dispatch, counters)
// Optional feature: define NTS_DISPATCHER_COUNTERS_EN for live frame/drop
// counters; otherwise both counter outputs are constant zero.
// -----------------------------------------------------------------------------
module nts_dispatcher
  import nts_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic           i_clk,
  input  logic           i_areset,
  nts_dispatcher_if.slave bus
);

  // Pointers/counts carry one extra bit so a completely full buffer is
  // distinguishable from an empty one.
  localparam logic [ADDR_WIDTH:0] PTR_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  nts_disp_state_e     state_q;
  logic [ADDR_WIDTH:0] wr_ptr_q;
  logic [ADDR_WIDTH:0] rd_ptr_q;
  logic [ADDR_WIDTH:0] count_q;
  nts_mask_t           mask_q;
  logic                avail_q;
  logic                skip_q;
  logic                overflow_q;

  logic                rx_word;
  logic                eof;
  logic                full;
  logic                fifo_empty;
  logic                rd_fire;
  logic                ram_we;

  assign rx_word    = |bus.i_rx_data_valid;
  assign eof        = bus.i_rx_good_frame | bus.i_rx_bad_frame;
  assign full       = (wr_ptr_q == PTR_FULL);
  assign fifo_empty = (rd_ptr_q == count_q) || (state_q != ST_READY);
  assign rd_fire    = bus.i_dispatch_fifo_rd_en && !fifo_empty;

  // In EMPTY the write pointer is zero, so both capture states share one
  // write address.
  always_comb begin
    ram_we = 1'b0;
    if (rx_word && !skip_q && !overflow_q) begin
      ram_we = (state_q == ST_EMPTY) || ((state_q == ST_WRITE) && !full);
    end
  end

  nts_dispatcher_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk     (i_clk),
    .i_areset  (i_areset),
    .i_wr_en   (ram_we),
    .i_wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .i_wr_data (bus.i_rx_data),
    .i_rd_en   (rd_fire),
    .i_rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .o_rd_data (bus.o_dispatch_fifo_rd_data)
  );

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mask_q     <= '0;
      avail_q    <= 1'b0;
      skip_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (skip_q) begin
            // tail of a frame that began while a packet was still held
            if (eof) skip_q <= 1'b0;
          end else if (rx_word) begin
            mask_q   <= bus.i_rx_data_valid;
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (bus.i_rx_good_frame) begin
              count_q <= wr_ptr_q + 1'b1;
              avail_q <= 1'b1;
              state_q <= ST_READY;
            end else if (bus.i_rx_bad_frame) begin
              wr_ptr_q <= '0;
            end else begin
              state_q <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (rx_word && full) begin
            if (eof) begin
              wr_ptr_q <= '0;
              state_q  <= ST_EMPTY;
            end else begin
              overflow_q <= 1'b1;
              state_q    <= ST_DROP;
            end
          end else begin
            if (rx_word) begin
              mask_q   <= bus.i_rx_data_valid;
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (bus.i_rx_good_frame) begin
              count_q <= wr_ptr_q + {{ADDR_WIDTH{1'b0}}, rx_word};
              avail_q <= 1'b1;
              state_q <= ST_READY;
            end else if (bus.i_rx_bad_frame) begin
              wr_ptr_q <= '0;
              state_q  <= ST_EMPTY;
            end
          end
        end

        ST_DROP: begin
          if (eof) begin
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            state_q    <= ST_EMPTY;
          end
        end

        ST_READY: begin
          if (skip_q) begin
            if (eof) skip_q <= 1'b0;
          end else if (rx_word && !eof) begin
            skip_q <= 1'b1;
          end
          if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
          if (bus.i_dispatch_packet_read_discard) begin
            avail_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
          end
        end

        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign bus.o_dispatch_packet_available = avail_q;
  assign bus.o_dispatch_data_valid       = mask_q;
  assign bus.o_dispatch_fifo_empty       = fifo_empty;

`ifdef NTS_DISPATCHER_COUNTERS_EN
  logic        frame_evt;
  logic        drop_evt;
  logic [31:0] frames_q;
  logic [31:0] drops_q;

  // Decodes the same end-of-frame outcomes the FSM acts on above.
  always_comb begin
    frame_evt = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (skip_q) begin
          drop_evt = eof;
        end else if (rx_word) begin
          frame_evt = bus.i_rx_good_frame;
          drop_evt  = !bus.i_rx_good_frame && bus.i_rx_bad_frame;
        end
      end
      ST_WRITE: begin
        if (rx_word && full) begin
          drop_evt = eof;
        end else begin
          frame_evt = bus.i_rx_good_frame;
          drop_evt  = !bus.i_rx_good_frame && bus.i_rx_bad_frame;
        end
      end
      ST_DROP:  drop_evt = eof;
      ST_READY: drop_evt = skip_q ? eof : (rx_word && eof);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      frames_q <= '0;
      drops_q  <= '0;
    end else begin
      if (frame_evt) frames_q <= frames_q + 32'd1;
      if (drop_evt)  drops_q  <= drops_q + 32'd1;
    end
  end

  assign bus.o_counter_frames = frames_q;
  assign bus.o_counter_drops  = drops_q;
`else
  assign bus.o_counter_frames = '0;
  assign bus.o_counter_drops  = '0;
`endif

endmodule

// File: tb/tb_nts_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_nts_dispatcher
// Directed bench for nts_dispatcher using a 4-word buffer (ADDR_WIDTH=2) so
// the overflow path is reachable with short frames.
// -----------------------------------------------------------------------------
module tb_nts_dispatcher;
  import nts_dispatcher_pkg::*;

`ifdef NTS_DISPATCHER_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int unsigned checks;
  int unsigned failures;
  int unsigned exp_frames;
  int unsigned exp_drops;

  nts_dispatcher_if bus ();

  nts_dispatcher #(.ADDR_WIDTH(2)) dut (
    .i_clk    (clk),
    .i_areset (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_frames"}, 64'(bus.o_counter_frames), CNT_EN ? 64'(exp_frames) : 64'd0);
    chk({tag, "_drops"},  64'(bus.o_counter_drops),  CNT_EN ? 64'(exp_drops)  : 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_avail"}, 64'(bus.o_dispatch_packet_available), 64'd0);
    chk({tag, "_empty"}, 64'(bus.o_dispatch_fifo_empty), 64'd1);
    chk({tag, "_dv"},    64'(bus.o_dispatch_data_valid), 64'd0);
    chk({tag, "_rdata"}, bus.o_dispatch_fifo_rd_data, 64'd0);
    chk({tag, "_frames"}, 64'(bus.o_counter_frames), 64'd0);
    chk({tag, "_drops"},  64'(bus.o_counter_drops), 64'd0);
  endtask

  // one MAC cycle: present word/mask and end-of-frame flags for one edge
  task automatic drive(input logic [7:0] m, input logic [63:0] d, input logic g, input logic b);
    bus.i_rx_data_valid = m;
    bus.i_rx_data       = d;
    bus.i_rx_good_frame = g;
    bus.i_rx_bad_frame  = b;
    step();
    bus.i_rx_data_valid = '0;
    bus.i_rx_data       = '0;
    bus.i_rx_good_frame = 1'b0;
    bus.i_rx_bad_frame  = 1'b0;
  endtask

  task automatic rd_word(input string tag, input logic [63:0] exp);
    bus.i_dispatch_fifo_rd_en = 1'b1;
    step();
    bus.i_dispatch_fifo_rd_en = 1'b0;
    chk(tag, bus.o_dispatch_fifo_rd_data, exp);
  endtask

  task automatic discard();
    bus.i_dispatch_packet_read_discard = 1'b1;
    step();
    bus.i_dispatch_packet_read_discard = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_frames = 0;
    exp_drops  = 0;
    rst = 1'b1;
    bus.i_rx_data_valid = '0;
    bus.i_rx_data       = '0;
    bus.i_rx_good_frame = 1'b0;
    bus.i_rx_bad_frame  = 1'b0;
    bus.i_dispatch_packet_read_discard = 1'b0;
    bus.i_dispatch_fifo_rd_en          = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");
    rst = 1'b0;
    step();

    // 3-word frame, good pulse on its own cycle
    drive(8'hFF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    drive(8'hFF, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
    drive(8'hC0, 64'h3333_0000_0000_0000, 1'b0, 1'b0);
    chk("f1_not_yet_avail", 64'(bus.o_dispatch_packet_available), 64'd0);
    drive(8'h00, 64'd0, 1'b1, 1'b0);
    exp_frames = 1;
    chk("f1_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    chk("f1_dv", 64'(bus.o_dispatch_data_valid), 64'hC0);
    chk("f1_not_empty", 64'(bus.o_dispatch_fifo_empty), 64'd0);
    chk_counters("f1");
    rd_word("f1_rd0", 64'h1111_1111_1111_1111);
    rd_word("f1_rd1", 64'h2222_2222_2222_2222);
    chk("f1_mid_not_empty", 64'(bus.o_dispatch_fifo_empty), 64'd0);
    rd_word("f1_rd2", 64'h3333_0000_0000_0000);
    chk("f1_empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    rd_word("f1_rd_when_empty", 64'h3333_0000_0000_0000);
    chk("f1_avail_hold", 64'(bus.o_dispatch_packet_available), 64'd1);
    discard();
    chk("f1_discarded", 64'(bus.o_dispatch_packet_available), 64'd0);

    // corrupt frame then a 1-word good frame (word and good in one cycle)
    drive(8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
    drive(8'hFF, 64'hBBBB_BBBB_BBBB_BBBB, 1'b0, 1'b1);
    exp_drops = 1;
    chk("bad_avail", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("bad_state", 64'(dut.state_q), 64'(ST_EMPTY));
    chk_counters("bad");
    drive(8'hF0, 64'hCCCC_CCCC_CCCC_CCCC, 1'b1, 1'b0);
    exp_frames = 2;
    chk("one_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    chk("one_dv", 64'(bus.o_dispatch_data_valid), 64'hF0);
    chk_counters("one");
    rd_word("one_rd0", 64'hCCCC_CCCC_CCCC_CCCC);
    chk("one_empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    discard();

    // stray good pulse in EMPTY is ignored
    drive(8'h00, 64'd0, 1'b1, 1'b0);
    chk("stray_good_avail", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk_counters("stray_good");

    // 5 words into a 4-word buffer
    for (int i = 0; i < 5; i++) drive(8'hFF, 64'(i + 1), 1'b0, 1'b0);
    chk("ovf_state_drop", 64'(dut.state_q), 64'(ST_DROP));
    drive(8'h00, 64'd0, 1'b1, 1'b0);
    exp_drops = 2;
    chk("ovf_avail", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("ovf_state_empty", 64'(dut.state_q), 64'(ST_EMPTY));
    chk_counters("ovf");

    // second frame arrives while the first is held
    drive(8'hFF, 64'h4444_4444_4444_4444, 1'b0, 1'b0);
    drive(8'hFF, 64'h5555_5555_5555_5555, 1'b1, 1'b0);
    exp_frames = 3;
    chk("held_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    drive(8'hFF, 64'h6666_6666_6666_6666, 1'b0, 1'b0);
    drive(8'h80, 64'h7777_7777_7777_7777, 1'b1, 1'b0);
    exp_drops = 3;
    chk("held_dv", 64'(bus.o_dispatch_data_valid), 64'hFF);
    chk_counters("held");
    rd_word("held_rd0", 64'h4444_4444_4444_4444);
    rd_word("held_rd1", 64'h5555_5555_5555_5555);
    chk("held_empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    discard();
    drive(8'hFF, 64'h8888_8888_8888_8888, 1'b0, 1'b0);
    drive(8'h00, 64'd0, 1'b1, 1'b0);
    exp_frames = 4;
    chk("third_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    rd_word("third_rd0", 64'h8888_8888_8888_8888);
    chk_counters("third");
    discard();

    // discard after 1 of 4 words read
    drive(8'hFF, 64'h9999_9999_9999_9999, 1'b0, 1'b0);
    drive(8'hFF, 64'hAAAA_0000_0000_AAAA, 1'b0, 1'b0);
    drive(8'hFF, 64'hBBBB_0000_0000_BBBB, 1'b0, 1'b0);
    drive(8'hFF, 64'hCCCC_0000_0000_CCCC, 1'b1, 1'b0);
    exp_frames = 5;
    chk("full4_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    rd_word("full4_rd0", 64'h9999_9999_9999_9999);
    discard();
    chk("part_avail", 64'(bus.o_dispatch_packet_available), 64'd0);
    chk("part_empty", 64'(bus.o_dispatch_fifo_empty), 64'd1);
    drive(8'hFF, 64'hDDDD_DDDD_DDDD_DDDD, 1'b0, 1'b0);
    drive(8'h0F, 64'hEEEE_EEEE_EEEE_EEEE, 1'b1, 1'b0);
    exp_frames = 6;
    chk("next_dv", 64'(bus.o_dispatch_data_valid), 64'h0F);
    rd_word("next_rd0", 64'hDDDD_DDDD_DDDD_DDDD);
    chk_counters("next");
    discard();

    // reset in the middle of a frame
    drive(8'hFF, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 1'b0);
    drive(8'hFF, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("arst");
    chk("arst_state", 64'(dut.state_q), 64'(ST_EMPTY));
    step();
    rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    step();
    drive(8'hFF, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    exp_frames = 1;
    chk("post_avail", 64'(bus.o_dispatch_packet_available), 64'd1);
    rd_word("post_rd0", 64'h1234_5678_9ABC_DEF0);
    chk_counters("post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nts_dispatcher.md
NTS_DISPATCHER -- requirements
Module: nts_dispatcher

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: log2 of the packet buffer depth in 64-bit words.
REQ-002 i_clk  in  1  sole clock; all logic is rising-edge.
REQ-003 i_areset  in  1  reset, asynchronous, active-high.
REQ-004 i_rx_data_valid  in  8  MAC byte-valid mask for the current word; nonzero marks a word as present.
REQ-005 i_rx_data  in  64  MAC data word, big-endian byte order.
REQ-006 i_rx_good_frame  in  1  MAC end-of-frame pulse, frame OK; arrives with or after the last word.
REQ-007 i_rx_bad_frame  in  1  MAC end-of-frame pulse, frame corrupt.
REQ-008 o_dispatch_packet_available  out  1  a complete packet is held for the engine.
REQ-009 i_dispatch_packet_read_discard  in  1  one-cycle engine pulse that releases the buffer.
REQ-010 o_dispatch_data_valid  out  8  byte mask of the packet's last word.
REQ-011 o_dispatch_fifo_empty  out  1  no unread words remain.
REQ-012 i_dispatch_fifo_rd_en  in  1  word read request.
REQ-013 o_dispatch_fifo_rd_data  out  64  read word.
REQ-014 o_counter_frames  out  32  good frames accepted.
REQ-015 o_counter_drops  out  32  frames dropped.

Function
REQ-016 The FSM SHALL use the states EMPTY, WRITE, READY and DROP.
REQ-017 EMPTY: the first cycle with i_rx_data_valid!=0 SHALL write that word to address 0 and enter WRITE.
REQ-018 WRITE: each valid word SHALL be written at the incrementing write pointer, and its mask SHALL be latched as the last-word mask.
REQ-019 WRITE + i_rx_good_frame SHALL go to READY with word_count = words written, including any word arriving in the same cycle.
REQ-020 WRITE + i_rx_bad_frame SHALL go to EMPTY with pointers cleared and SHALL count as a drop.
REQ-021 A valid word arriving in WRITE when word_count == 2**ADDR_WIDTH SHALL set overflow, write nothing, and enter DROP.
REQ-022 DROP SHALL ignore words and, on good or bad frame, go to EMPTY and count one drop.
REQ-023 READY SHALL assert o_dispatch_packet_available=1 and hold o_dispatch_data_valid stable.
REQ-024 o_dispatch_fifo_empty SHALL be (rd_ptr == word_count) or (state != READY).
REQ-025 i_dispatch_fifo_rd_en with empty=0 SHALL register buf[rd_ptr] onto o_dispatch_fifo_rd_data the next cycle (1-cycle latency) and SHALL increment rd_ptr.
REQ-026 rd_en while empty SHALL be ignored, leaving rd_data and rd_ptr unchanged.
REQ-027 READY + i_dispatch_packet_read_discard SHALL drop available, clear pointers, and enter EMPTY next cycle, whether or not all words were read.
REQ-028 A frame that starts in READY, or in the cycle a discard is taken, SHALL be dropped whole: internal "skip" flag set, one drop counted at its end-of-frame, no buffer write.
REQ-029 A discard pulse outside READY SHALL be ignored.
REQ-030 A good-frame pulse with no preceding word in EMPTY SHALL be ignored and not counted.
REQ-031 Counters SHALL wrap modulo 2**32.

Reset
REQ-032 On i_areset: state=EMPTY, pointers=0, skip=0, overflow=0.
REQ-033 On i_areset: o_dispatch_packet_available=0, o_dispatch_fifo_empty=1, o_dispatch_data_valid=0, o_dispatch_fifo_rd_data=0, counters=0.
REQ-034 Reset mid-frame or mid-read SHALL abandon the packet; the buffer RAM contents are not cleared.

Configuration
REQ-035 With NTS_DISPATCHER_COUNTERS_EN defined: o_counter_frames/o_counter_drops SHALL be live registers per REQ-014/015/031.
REQ-036 Without NTS_DISPATCHER_COUNTERS_EN: both counter outputs SHALL be constant 0, no counter flops SHALL be inferred, and all other behaviour SHALL be identical.

Structure
REQ-037 The shared NTS package SHALL hold the dispatcher state encodings and the 64-bit word / 8-bit mask width constants.
REQ-038 The buffer SHALL be one sub-module, nts_dispatcher_ram: a simple dual-port RAM with 2**ADDR_WIDTH x 64 and a registered read.

Verification
REQ-039 Bench: 3-word frame (0x1111..., 0x2222..., 0x33 with mask 8'hC0) + good -> available=1, data_valid=8'hC0; 3 reads return the words in order, then empty=1; frames=1.
REQ-040 Bench: frame with bad_frame -> available stays 0; drops=1; a following good 1-word frame is delivered normally.
REQ-041 Bench: ADDR_WIDTH=2, 5-word frame + good -> no available; drops=1; state returns to EMPTY.
REQ-042 Bench: second frame arrives while READY -> first packet data intact; drops=1; after discard, a third frame is delivered.
REQ-043 Bench: discard after reading 1 of 4 words -> next cycle available=0, empty=1; the next packet reads from word 0.
REQ-044 Bench: areset asserted mid-WRITE -> all outputs at reset values immediately; a clean frame after release is delivered with frames=1.
